// File: rtl/pe_array_feeder_if.sv
// Handshake and PE-row drive bundle between the tile controller and the PE array feeder.
// Both input streams are valid/ready: a beat transfers on a rising edge where valid and ready are both high.
interface pe_array_feeder_if #(
    parameter int data_width         = 24,
    parameter int w_tile_column_size = 6,
    parameter int w_tile_row_size    = 6
);
    logic                                         start;
    logic                                         w_valid;
    logic                                         w_ready;
    logic [data_width*w_tile_column_size-1:0]     w_data;
    logic                                         a_valid;
    logic                                         a_ready;
    logic                                         a_last;
    logic [data_width*w_tile_row_size-1:0]        a_data;
    logic                                         w_en;
    logic                                         w_compute;
    logic [data_width*w_tile_column_size-1:0]     weight_out;
    logic [data_width*w_tile_row_size-1:0]        active_out;
    logic                                         busy;
    logic                                         done;
    logic [1:0]                                   fsm_state;

    modport master (
        output start, w_valid, w_data, a_valid, a_last, a_data,
        input  w_ready, a_ready, w_en, w_compute, weight_out, active_out, busy, done, fsm_state
    );

    modport slave (
        input  start, w_valid, w_data, a_valid, a_last, a_data,
        output w_ready, a_ready, w_en, w_compute, weight_out, active_out, busy, done, fsm_state
    );
endinterface

// File: rtl/pe_array_feeder.sv
// Systolic PE array front end: preloads a weight tile row by row, then streams
// activation vectors into the array's left edge with a per-row triangular skew.
module pe_array_feeder #(
    parameter int data_width         = 24,
    parameter int w_tile_column_size = 6,
    parameter int w_tile_row_size    = 6
) (
    input logic              clk,
    input logic              rst,
    pe_array_feeder_if.slave bus
);

    localparam int WCW = $clog2(w_tile_row_size + 1);
    localparam int DCW = $clog2(w_tile_row_size + w_tile_column_size);
    localparam logic [WCW-1:0] W_LAST = WCW'(w_tile_row_size - 1);
    localparam logic [WCW-1:0] W_TERM = WCW'(w_tile_row_size);
    localparam logic [DCW-1:0] D_LAST = DCW'(w_tile_row_size + w_tile_column_size - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                                   state;
    state_t                                   state_next;
    logic [WCW-1:0]                           wcnt;
    logic [DCW-1:0]                           dcnt;
    logic                                     w_fire;
    logic                                     a_fire;
    logic                                     w_en_q;
    logic                                     done_q;
    logic [data_width*w_tile_column_size-1:0] weight_q;

    // Ready and enables come straight from the state register, never from valid.
    assign bus.w_ready   = (state == LOAD);
    assign bus.a_ready   = (state == COMPUTE);
    assign bus.busy      = (state != IDLE);
    assign bus.w_compute = (state == COMPUTE) || (state == DRAIN);
    assign bus.fsm_state = state;
    assign bus.w_en       = w_en_q;
    assign bus.done       = done_q;
    assign bus.weight_out = weight_q;

    assign w_fire = bus.w_valid && (state == LOAD);
    assign a_fire = bus.a_valid && (state == COMPUTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    if (w_fire && (wcnt == W_LAST)) state_next = COMPUTE;
            COMPUTE: if (a_fire && bus.a_last) state_next = DRAIN;
            DRAIN:   if (dcnt == D_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt   <= '0;
            dcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DRAIN) && (dcnt == D_LAST);
            if (state == IDLE) begin
                wcnt <= '0;
            end else if (w_fire && (wcnt != W_TERM)) begin
                wcnt <= wcnt + 1'b1;
            end
            // Held at zero through COMPUTE so DRAIN always starts counting from 0.
            if (state == COMPUTE) begin
                dcnt <= '0;
            end else if ((state == DRAIN) && (dcnt != D_LAST)) begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en_q   <= 1'b0;
            weight_q <= '0;
        end else begin
            w_en_q <= w_fire;
            if (w_fire) begin
                weight_q <= bus.w_data;
            end
        end
    end

    // Row r gets a register chain of depth r+1; bubbles shift in as zeros.
    for (genvar r = 0; r < w_tile_row_size; r++) begin : g_row
        logic [data_width-1:0] taps [0:r];
        logic [data_width-1:0] feed;

        assign feed = a_fire ? bus.a_data[r*data_width +: data_width] : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= r; i++) begin
                    taps[i] <= '0;
                end
            end else begin
                taps[0] <= feed;
                for (int i = 1; i <= r; i++) begin
                    taps[i] <= taps[i-1];
                end
            end
        end

        assign bus.active_out[r*data_width +: data_width] = taps[r];
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: drivers push expected weight beats, skewed
// activation frames and done times into queues; a negedge monitor pops and compares.
module tb_pe_array_feeder;

  localparam int DW = 24;
  localparam int C  = 6;
  localparam int R  = 6;
  localparam int WW = DW * C;
  localparam int AW = DW * R;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_array_feeder_if #(.data_width(DW), .w_tile_column_size(C), .w_tile_row_size(R)) bus ();

  pe_array_feeder #(.data_width(DW), .w_tile_column_size(C), .w_tile_row_size(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WW-1:0] w_exp_q[$];
  int            w_cyc_q[$];
  logic [AW-1:0] a_exp_q[$];
  int            done_cyc_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.w_en) begin
        check("w_en_expected", w_exp_q.size() > 0, 1);
        if (w_exp_q.size() > 0) begin
          check("weight_out", bus.weight_out, w_exp_q.pop_front());
          check("w_en_cycle", cyc, w_cyc_q.pop_front());
        end
      end
      if (bus.w_compute) begin
        check("compute_frame_expected", a_exp_q.size() > 0, 1);
        if (a_exp_q.size() > 0) check("active_out", bus.active_out, a_exp_q.pop_front());
      end else begin
        check("active_idle_zero", bus.active_out, 0);
      end
      if (bus.done) begin
        check("done_expected", done_cyc_q.size() > 0, 1);
        if (done_cyc_q.size() > 0) check("done_cycle", cyc, done_cyc_q.pop_front());
        check("busy_at_done", bus.busy, 0);
        check("w_compute_at_done", bus.w_compute, 0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_weight_out"}, bus.weight_out, 0);
    check({tag, "_active_out"}, bus.active_out, 0);
    check({tag, "_w_en"}, bus.w_en, 0);
    check({tag, "_w_compute"}, bus.w_compute, 0);
    check({tag, "_w_ready"}, bus.w_ready, 0);
    check({tag, "_a_ready"}, bus.a_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_state"}, bus.fsm_state, 0);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("state_load", bus.fsm_state, 1);
  endtask

  task automatic load_weights(input int base, input int gap, input int nbeats, input bit a_noise);
    for (int k = 0; k < nbeats; k++) begin
      logic [WW-1:0] row;
      int t;
      for (int j = 0; j < C; j++) row[j*DW +: DW] = DW'(base + 16 * k + j);
      bus.w_valid = 1'b1;
      bus.w_data  = row;
      bus.a_valid = a_noise;
      bus.a_last  = a_noise;
      bus.a_data  = {AW{a_noise}};
      t = 0;
      @(negedge clk);
      while (!bus.w_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("w_ready_in_load", bus.w_ready, 1);
      check("a_ready_in_load", bus.a_ready, 0);
      w_exp_q.push_back(row);
      w_cyc_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      bus.w_valid = 1'b0;
      bus.a_valid = 1'b0;
      bus.a_last  = 1'b0;
      bus.a_data  = '0;
      if (k < nbeats - 1) repeat (gap) tick();
    end
  endtask

  // Entered one delta after the edge that moved the FSM into COMPUTE (frame 0).
  task automatic run_acts(input logic [AW-1:0] vecs [3], input int n, input int gap,
                          input bit noise, input bit restart);
    int d [3];
    int last_d;
    int c0;
    int t;
    c0 = cyc;
    for (int i = 0; i < 3; i++) d[i] = 1 + i * (gap + 1);
    last_d = d[n-1];
    for (int k = 0; k < last_d + 11; k++) begin
      logic [AW-1:0] f;
      f = '0;
      for (int r = 0; r < R; r++)
        for (int i = 0; i < n; i++)
          if (d[i] + r == k) f[r*DW +: DW] = vecs[i][r*DW +: DW];
      a_exp_q.push_back(f);
    end
    done_cyc_q.push_back(c0 + last_d + 11);
    for (int i = 0; i < n; i++) begin
      bus.a_valid = 1'b1;
      bus.a_data  = vecs[i];
      bus.a_last  = (i == n - 1);
      @(negedge clk);
      check("a_ready_in_compute", bus.a_ready, 1);
      check("w_ready_in_compute", bus.w_ready, 0);
      @(posedge clk);
      #1;
      bus.a_valid = 1'b0;
      bus.a_last  = 1'b0;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          bus.start   = noise;
          bus.w_valid = noise;
          tick();
          check("a_ready_held", bus.a_ready, 1);
        end
        bus.start   = 1'b0;
        bus.w_valid = 1'b0;
      end
    end
    check("drain_state", bus.fsm_state, 3);
    t = 0;
    while (!bus.done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", bus.done, 1);
    bus.start = restart;
    tick();
    bus.start = 1'b0;
    check("busy_after_done", bus.busy, restart);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] vv [3];
    bus.start   = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.a_valid = 1'b0;
    bus.a_last  = 1'b0;
    bus.a_data  = '0;
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset in the middle of a weight load drops the partial tile.
    do_start();
    load_weights(0, 0, 3, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("mid_load_reset");
    w_exp_q.delete();
    w_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_after_reset", bus.busy, 0);

    // Back-to-back weights with stray a_valid, then a single skewed vector.
    do_start();
    load_weights(0, 0, 6, 1'b1);
    check("a_ready_after_load", bus.a_ready, 1);
    check("state_compute", bus.fsm_state, 2);
    for (int r = 0; r < R; r++) vv[0][r*DW +: DW] = DW'(r);
    vv[1] = '0;
    vv[2] = '0;
    run_acts(vv, 1, 0, 1'b0, 1'b0);
    check("weights_drained_1", w_exp_q.size(), 0);

    // Weight gaps, then bubbled vectors with stray start/w_valid; restart from the done cycle.
    do_start();
    load_weights(256, 1, 6, 1'b0);
    check("a_ready_after_gap_load", bus.a_ready, 1);
    for (int r = 0; r < R; r++) begin
      vv[0][r*DW +: DW] = DW'(24'h100 + r);
      vv[1][r*DW +: DW] = DW'(24'h200 + r);
      vv[2][r*DW +: DW] = DW'(24'h300 + r);
    end
    run_acts(vv, 3, 2, 1'b1, 1'b1);
    check("state_load_after_restart", bus.fsm_state, 1);

    // Tile started from the done cycle: fresh weights, two back-to-back vectors.
    load_weights(512, 0, 6, 1'b0);
    for (int r = 0; r < R; r++) begin
      vv[0][r*DW +: DW] = DW'(24'hA00 + r);
      vv[1][r*DW +: DW] = DW'(24'hB00 + r);
    end
    run_acts(vv, 2, 0, 1'b0, 1'b0);

    // a_last alone while idle must not start anything.
    bus.a_last = 1'b1;
    repeat (3) tick();
    bus.a_last = 1'b0;
    check("idle_ignores_a_last", bus.busy, 0);
    check("w_queue_empty", w_exp_q.size(), 0);
    check("a_queue_empty", a_exp_q.size(), 0);
    check("done_queue_empty", done_cyc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_array_feeder.md
# pe_array_feeder

Front-end stage of the systolic PE array; feeds the top of the stack of PE rows. It preloads one weight tile by streaming weight rows into the top row with `w_en`. It then streams activation vectors into the left edge of every row with the triangular skew the array requires, holding `w_compute` until the wavefront has fully crossed the array. Both input streams use valid/ready handshakes; a `done` pulse marks the end of each tile pass.

## Interface
- `data_width`, 24, width of one weight / activation element
- `w_tile_column_size`, 6, PE columns per row (weight row width)
- `w_tile_row_size`, 6, number of PE rows (activation vector width, skew depth)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a tile pass; sampled only in IDLE
- `w_valid`  in  1  weight row beat valid
- `w_ready`  out  1  feeder accepts weight beat
- `w_data`  in  data_width*w_tile_column_size  one weight row, element j in bits [(j+1)*data_width-1 : j*data_width]
- `a_valid`  in  1  activation vector valid
- `a_ready`  out  1  feeder accepts activation vector
- `a_last`  in  1  marks final activation vector of the pass
- `a_data`  in  data_width*w_tile_row_size  activation vector, element r destined for row r
- `w_en`  out  1  weight shift enable to every PE row
- `w_compute`  out  1  compute enable to every PE row
- `weight_out`  out  data_width*w_tile_column_size  drives top row's in_weight_above
- `active_out`  out  data_width*w_tile_row_size  element r drives row r's active_left
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse at end of DRAIN

## Operation
- FSM states: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE: `start`=1 -> LOAD, `wcnt` cleared. All other inputs ignored.
- LOAD: `w_ready`=1. Each handshake (`w_valid`&`w_ready`) registers `w_data` into `weight_out` and sets `w_en`=1 on the next cycle; `w_en`=0 on cycles with no handshake. Rows are sent bottom row first. After handshake number `w_tile_row_size` -> COMPUTE.
- COMPUTE: `a_ready`=1, `w_compute`=1. On each handshake, element r enters a skew line of depth r+1. The line is registered, so row 0 output appears next cycle. On cycles without a handshake a zero bubble enters all lines. A handshake with `a_last`=1 -> DRAIN, with `dcnt` cleared.
- DRAIN: `a_ready`=0, `w_compute`=1, zeros enter the skew lines. Runs exactly `w_tile_row_size + w_tile_column_size - 1` cycles, then -> IDLE with `done`=1 for one cycle.
- `start` while busy is ignored. `w_valid` outside LOAD and `a_valid` outside COMPUTE are ignored; ready stays 0.
- `a_last` without `a_valid` has no effect.
- Skew lines keep shifting in every state; their contents are zero outside COMPUTE/DRAIN.

## Timing
- Reset (asynchronous, any state, including mid-LOAD or mid-DRAIN): state=IDLE, counters=0, skew lines=0. Outputs: `weight_out`=0, `active_out`=0, `w_en`=0, `w_compute`=0, `w_ready`=0, `a_ready`=0, `busy`=0, `done`=0.
- `w_ready`, `a_ready`, `busy` and `w_compute` are decoded from registered state; no combinational path from valid to ready.
- Weight latency: beat accepted at edge t -> `weight_out`/`w_en` valid during cycle t+1.
- Activation latency: vector accepted at edge t -> row r element on `active_out` during cycle t+1+r.
- `w_compute` rises the cycle after entering COMPUTE. It falls the cycle after the last DRAIN cycle, the same cycle `done` is high.
- `start` in the cycle `done` is high is accepted, since the FSM is already in IDLE.
- Counters: `wcnt` is $clog2(w_tile_row_size+1) bits and saturates at its terminal value. `dcnt` is sized for `w_tile_row_size+w_tile_column_size-1`.

## Test plan
- Reset mid-LOAD: assert `rst` after 3 of 6 weight beats -> all outputs 0 immediately. A later `start` requires 6 fresh beats.
- Weight load, defaults: `start`, then 6 back-to-back beats with row k element j = 16·k+j -> `w_en` high for 6 consecutive cycles, starting 1 cycle after the first handshake. `weight_out` mirrors each beat one cycle late. FSM enters COMPUTE after the 6th beat.
- Weight gaps: `w_valid` low on alternate cycles -> `w_en` pulses only after handshakes. Exactly 6 pulses before `a_ready` rises.
- Skew check: one vector {5,4,3,2,1,0}·1 (row r = r) accepted at cycle t with `a_last` -> row r shows value r at t+1+r, zero otherwise. DRAIN lasts 11 cycles. `done` pulses once; `busy` falls with it.
- Bubble insertion: 3 vectors with `a_valid` gap of 2 cycles between each -> `active_out` row 0 shows v0,0,0,v1,0,0,v2. Every row r repeats this pattern delayed r cycles.
- Ignored inputs: `a_valid`=1 during LOAD and `start`=1 during COMPUTE -> `a_ready`=0, no state change, no extra `done`.
